// File: rtl/sync_fifo_thr_pkg.sv
// Shared sizing helpers and default threshold values for the threshold FIFO family.
package sync_fifo_thr_pkg;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Default almost-full sits two words below capacity
  function automatic int unsigned afull_default(input int unsigned addr_width);
    return depth_of(addr_width) - 32'd2;
  endfunction

  localparam int unsigned AEMPTY_DEFAULT = 1;

endpackage

// File: rtl/fifo_mem_2p.sv
// Register-array storage: synchronous write port, asynchronous read port, no reset.
module fifo_mem_2p
  import sync_fifo_thr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_CLK,
  input  logic                  i_WE,
  input  logic [ADDR_WIDTH-1:0] i_WADDR,
  input  logic [DATA_WIDTH-1:0] i_WDATA,
  input  logic [ADDR_WIDTH-1:0] i_RADDR,
  output logic [DATA_WIDTH-1:0] o_RDATA
);

  localparam int DEPTH = int'(depth_of(ADDR_WIDTH));

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_CLK) begin
    if (i_WE) r_mem[i_WADDR] <= i_WDATA;
  end

  assign o_RDATA = r_mem[i_RADDR];

endmodule

// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty thresholds,
// optional first-word-fall-through read, sticky error flags and synchronous flush.
module sync_fifo_thr
  import sync_fifo_thr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = 0
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_W_INC,
  input  logic [DATA_WIDTH-1:0] i_WR_DATA,
  input  logic                  i_R_INC,
  input  logic                  i_FLUSH,
  input  logic                  i_CLR_ERR,
  input  logic [ADDR_WIDTH:0]   i_AFULL_TH,
  input  logic [ADDR_WIDTH:0]   i_AEMPTY_TH,
  output logic [DATA_WIDTH-1:0] o_RD_DATA,
  output logic                  o_FULL,
  output logic                  o_EMPTY,
  output logic                  o_ALMOST_FULL,
  output logic                  o_ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   o_COUNT,
  output logic                  o_OVERFLOW,
  output logic                  o_UNDERFLOW
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full, r_empty, r_ovf, r_unf;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic [DATA_WIDTH-1:0] w_mem_rd;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  w_rd_ok, w_wr_ok, w_ovf_set, w_unf_set, w_rd_load;

  // Flush suppresses both ports; the reset term keeps a clock edge during reset from writing storage
  assign w_rd_ok   = i_R_INC & ~r_empty & ~i_FLUSH;
  assign w_wr_ok   = i_W_INC & (~r_full | w_rd_ok) & ~i_FLUSH & ~i_RST;
  assign w_ovf_set = i_W_INC & ~i_FLUSH & ~(~r_full | w_rd_ok);
  assign w_unf_set = i_R_INC & ~i_FLUSH & r_empty;

  assign w_count_nxt = r_count + {{ADDR_WIDTH{1'b0}}, w_wr_ok} - {{ADDR_WIDTH{1'b0}}, w_rd_ok};

  fifo_mem_2p #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .i_CLK  (i_CLK),
    .i_WE   (w_wr_ok),
    .i_WADDR(r_wr_ptr),
    .i_WDATA(i_WR_DATA),
    .i_RADDR(r_rd_ptr),
    .o_RDATA(w_mem_rd)
  );

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (i_FLUSH) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~i_CLR_ERR);
      r_unf <= w_unf_set | (r_unf & ~i_CLR_ERR);
    end
  end

  // FWFT keeps a shadow of the visible head so the output holds once the FIFO drains
  assign w_rd_load = (FWFT == 0) ? w_rd_ok : ~r_empty;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST)          r_rd_data <= '0;
    else if (w_rd_load) r_rd_data <= w_mem_rd;
  end

  assign o_RD_DATA      = ((FWFT != 0) && !r_empty) ? w_mem_rd : r_rd_data;
  assign o_FULL         = r_full;
  assign o_EMPTY        = r_empty;
  assign o_COUNT        = r_count;
  assign o_ALMOST_FULL  = (r_count >= i_AFULL_TH);
  assign o_ALMOST_EMPTY = (r_count <= i_AEMPTY_TH);
  assign o_OVERFLOW     = r_ovf;
  assign o_UNDERFLOW    = r_unf;

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Directed bench for sync_fifo_thr: queue-based reference model checked every cycle on
// registered and FWFT instances, plus literal expectations from the test plan.
module tb_sync_fifo_thr;
  import sync_fifo_thr_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk, rst, w_inc, r_inc, flush, clr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   afull_th, aempty_th;

  logic [DW-1:0] rd0, rd1;
  logic          full0, empty0, af0, ae0, ovf0, unf0;
  logic          full1, empty1, af1, ae1, ovf1, unf1;
  logic [AW:0]   cnt0, cnt1;

  int vectors = 0;
  int errors  = 0;

  sync_fifo_thr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_reg (
    .i_CLK(clk), .i_RST(rst), .i_W_INC(w_inc), .i_WR_DATA(wr_data), .i_R_INC(r_inc),
    .i_FLUSH(flush), .i_CLR_ERR(clr), .i_AFULL_TH(afull_th), .i_AEMPTY_TH(aempty_th),
    .o_RD_DATA(rd0), .o_FULL(full0), .o_EMPTY(empty0), .o_ALMOST_FULL(af0),
    .o_ALMOST_EMPTY(ae0), .o_COUNT(cnt0), .o_OVERFLOW(ovf0), .o_UNDERFLOW(unf0)
  );

  sync_fifo_thr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_fwft (
    .i_CLK(clk), .i_RST(rst), .i_W_INC(w_inc), .i_WR_DATA(wr_data), .i_R_INC(r_inc),
    .i_FLUSH(flush), .i_CLR_ERR(clr), .i_AFULL_TH(afull_th), .i_AEMPTY_TH(aempty_th),
    .o_RD_DATA(rd1), .o_FULL(full1), .o_EMPTY(empty1), .o_ALMOST_FULL(af1),
    .o_ALMOST_EMPTY(ae1), .o_COUNT(cnt1), .o_OVERFLOW(ovf1), .o_UNDERFLOW(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus the last value shown at the head
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd0, m_last;
  bit            m_ovf, m_unf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_rd0 = '0; m_last = '0; m_ovf = 0; m_unf = 0;
    end else begin
      bit rok, wok, oset, uset;
      rok = 0; wok = 0; oset = 0; uset = 0;
      if (q.size() > 0) m_last = q[0];
      if (flush) q.delete();
      else begin
        rok = r_inc && (q.size() > 0);
        wok = w_inc && ((q.size() < DEPTH) || rok);
        if (rok) m_rd0 = q.pop_front();
        if (wok) q.push_back(wr_data);
        oset = w_inc && !wok;
        uset = r_inc && !rok;
      end
      m_ovf = oset || (m_ovf && !clr);
      m_unf = uset || (m_unf && !clr);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      int n;
      n = q.size();
      chk("count_r", 32'(cnt0), n);           chk("count_f", 32'(cnt1), n);
      chk("full_r", 32'(full0), int'(n == DEPTH)); chk("full_f", 32'(full1), int'(n == DEPTH));
      chk("empty_r", 32'(empty0), int'(n == 0));   chk("empty_f", 32'(empty1), int'(n == 0));
      chk("afull_r", 32'(af0), int'(n >= int'(afull_th)));
      chk("afull_f", 32'(af1), int'(n >= int'(afull_th)));
      chk("aempty_r", 32'(ae0), int'(n <= int'(aempty_th)));
      chk("aempty_f", 32'(ae1), int'(n <= int'(aempty_th)));
      chk("ovf_r", 32'(ovf0), 32'(m_ovf)); chk("ovf_f", 32'(ovf1), 32'(m_ovf));
      chk("unf_r", 32'(unf0), 32'(m_unf)); chk("unf_f", 32'(unf1), 32'(m_unf));
      chk("rd_reg", 32'(rd0), 32'(m_rd0));
      chk("rd_fwft", 32'(rd1), (n > 0) ? 32'(q[0]) : 32'(m_last));
    end
  end

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                     input bit f = 0, input bit c = 0);
    w_inc = w; wr_data = d; r_inc = r; flush = f; clr = c;
    @(posedge clk); #1;
    w_inc = 0; r_inc = 0; flush = 0; clr = 0;
  endtask

  logic [8:0]    ae_exp, af_exp;
  logic [DW-1:0] drain_exp [8];

  initial begin
    rst = 1; w_inc = 0; r_inc = 0; flush = 0; clr = 0; wr_data = '0;
    afull_th  = (AW+1)'(afull_default(AW));
    aempty_th = (AW+1)'(AEMPTY_DEFAULT);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(cnt0), 0); chk("rst_empty", 32'(empty0), 1);
    chk("rst_full", 32'(full0), 0); chk("rst_rd", 32'(rd0), 0);
    chk("rst_ovf", 32'(ovf0), 0);   chk("rst_unf", 32'(unf0), 0);
    rst = 0;
    @(posedge clk); #1;

    // 1: basic order and one-edge read latency
    cyc(1, 8'd10, 0); cyc(1, 8'd20, 0); cyc(1, 8'd80, 0); cyc(1, 8'd30, 0);
    chk("t1_count4", 32'(cnt0), 4);
    cyc(0, 0, 1); chk("t1_rd0", 32'(rd0), 10); chk("t1_count3", 32'(cnt0), 3);
    cyc(0, 0, 1); chk("t1_rd1", 32'(rd0), 20);
    cyc(0, 0, 1); chk("t1_rd2", 32'(rd0), 80);
    cyc(0, 0, 1); chk("t1_rd3", 32'(rd0), 30);
    chk("t1_count0", 32'(cnt0), 0); chk("t1_empty", 32'(empty0), 1);

    // 2: fill past capacity
    for (int i = 0; i < 9; i++) begin
      cyc(1, 8'(40 + 10 * i), 0);
      if (i == 7) chk("t2_full", 32'(full0), 1);
    end
    chk("t2_ovf", 32'(ovf0), 1); chk("t2_count", 32'(cnt0), 8);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      chk("t2_rd", 32'(rd0), 32'(40 + 10 * i));
    end
    cyc(0, 0, 0, 0, 1);
    chk("t2_clr", 32'(ovf0), 0);

    // 3: threshold flags across all counts
    afull_th = 4'd6; aempty_th = 4'd2;
    ae_exp = 9'b000000111; af_exp = 9'b111000000;
    for (int c = 0; c <= 8; c++) begin
      #1;
      chk("t3_aempty", 32'(ae0), 32'(ae_exp[c]));
      chk("t3_afull", 32'(af0), 32'(af_exp[c]));
      if (c < 8) cyc(1, 8'(c + 1), 0);
    end

    // 4: simultaneous read and write while full
    for (int k = 0; k < 3; k++) begin
      cyc(1, 8'hA1 + 8'(k), 1);
      chk("t4_count", 32'(cnt0), 8); chk("t4_full", 32'(full0), 1);
      chk("t4_ovf", 32'(ovf0), 0);
    end
    drain_exp = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      chk("t4_drain", 32'(rd0), 32'(drain_exp[i]));
    end

    // 5: underflow, clear priority, flush
    cyc(0, 0, 1);
    chk("t5_unf", 32'(unf0), 1); chk("t5_rd_hold", 32'(rd0), 32'h A3);
    cyc(0, 0, 1, 0, 1);
    chk("t5_set_wins", 32'(unf0), 1);
    cyc(0, 0, 0, 0, 1);
    chk("t5_clr", 32'(unf0), 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'h11 + 8'(i), 0);
    chk("t5_count5", 32'(cnt0), 5);
    cyc(1, 8'h77, 0, 1);
    chk("t5_flush_cnt", 32'(cnt0), 0); chk("t5_flush_empty", 32'(empty0), 1);
    chk("t5_flush_ovf", 32'(ovf0), 0);
    cyc(1, 8'h99, 0);
    chk("t5_fwft_head", 32'(rd1), 32'h99);
    cyc(0, 0, 1);
    chk("t5_after_flush", 32'(rd0), 32'h99);

    // threshold extremes: zero always asserts, above depth never asserts
    afull_th = 4'd0; #1;
    chk("th0_afull", 32'(af0), 1);
    afull_th = 4'd9;
    for (int i = 0; i < 8; i++) cyc(1, 8'hC0 + 8'(i), 0);
    chk("th9_full", 32'(full0), 1); chk("th9_afull", 32'(af0), 0);
    cyc(0, 0, 0, 1);
    afull_th = 4'd6;

    // 6: FWFT fall-through, then asynchronous reset mid-stream
    cyc(1, 8'h55, 0);
    chk("t6_fwft", 32'(rd1), 32'h55);
    for (int i = 0; i < 4; i++) cyc(1, 8'h56 + 8'(i), 0);
    chk("t6_count5", 32'(cnt1), 5);
    rst = 1; #1;
    chk("t6_rst_cnt_f", 32'(cnt1), 0); chk("t6_rst_empty_f", 32'(empty1), 1);
    chk("t6_rst_cnt_r", 32'(cnt0), 0); chk("t6_rst_empty_r", 32'(empty0), 1);
    @(posedge clk); #1;
    rst = 0;
    cyc(0, 0, 0);
    cyc(1, 8'h3C, 0);
    chk("t6_post_fwft", 32'(rd1), 32'h3C);
    cyc(0, 0, 1);
    chk("t6_post_rd", 32'(rd0), 32'h3C);
    cyc(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_thr.md
Name: sync_fifo_thr

Overview:
- Single-clock, parametrised FIFO. It is the next-generation buffer for same-domain paths in the system, such as ALU result queueing and register-file burst staging.
- Generalises the existing FIFO in width and depth.
- Adds new features over the existing FIFO:
  - occupancy count;
  - programmable almost-full and almost-empty thresholds;
  - a first-word-fall-through (FWFT) read mode;
  - sticky overflow and underflow error flags;
  - synchronous flush.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (8 by default)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word presented on o_RD_DATA without a read request

Ports:
i_CLK  in  1  single clock for the block
i_RST  in  1  asynchronous, active-high reset
i_W_INC  in  1  write request
i_WR_DATA  in  DATA_WIDTH  write data
i_R_INC  in  1  read request
i_FLUSH  in  1  synchronous flush; empties the FIFO
i_CLR_ERR  in  1  clears the sticky error flags
i_AFULL_TH  in  ADDR_WIDTH+1  almost-full threshold
i_AEMPTY_TH  in  ADDR_WIDTH+1  almost-empty threshold
o_RD_DATA  out  DATA_WIDTH  read data
o_FULL  out  1  count == DEPTH
o_EMPTY  out  1  count == 0
o_ALMOST_FULL  out  1  count >= i_AFULL_TH
o_ALMOST_EMPTY  out  1  count <= i_AEMPTY_TH
o_COUNT  out  ADDR_WIDTH+1  current occupancy
o_OVERFLOW  out  1  sticky: a write was rejected
o_UNDERFLOW  out  1  sticky: a read was rejected

Behaviour:
- Clocking and reset:
  - One clock only, i_CLK.
  - Reset is i_RST, asynchronous and active-high.
  - On reset: write/read pointers = 0, o_COUNT = 0, o_EMPTY = 1, o_FULL = 0, o_RD_DATA = 0, o_OVERFLOW = 0, o_UNDERFLOW = 0.
  - Storage contents are not reset.
- Acceptance rules:
  - rd_ok = i_R_INC & !o_EMPTY
  - wr_ok = i_W_INC & (!o_FULL | rd_ok)
  - When full and both requests are asserted, both are accepted and the count is unchanged.
  - When empty and both are asserted, the write is accepted, the read is rejected, and underflow is flagged.
- Register updates on each edge:
  - Pointers advance by 1 on each accepted access and wrap naturally modulo DEPTH.
  - o_COUNT += wr_ok - rd_ok.
  - o_FULL and o_EMPTY are registered and updated on the same edge as o_COUNT.
- Threshold flags:
  - o_ALMOST_FULL and o_ALMOST_EMPTY are combinational from the registered count and the threshold inputs.
  - i_AFULL_TH = 0 makes o_ALMOST_FULL constantly 1.
  - i_AFULL_TH > DEPTH makes o_ALMOST_FULL never assert.
- Read data, FWFT = 0:
  - o_RD_DATA loads mem[rd_ptr] on the edge of an accepted read.
  - Otherwise it holds its value, including during rejected reads.
- Read data, FWFT = 1:
  - o_RD_DATA = mem[rd_ptr] whenever !o_EMPTY; it holds its last value when empty.
  - A word written into an empty FIFO appears on the edge following the write.
  - i_R_INC acts as a pop.
- Error flags:
  - o_OVERFLOW sets on i_W_INC & !wr_ok.
  - o_UNDERFLOW sets on i_R_INC & !rd_ok.
  - Both clear on i_CLR_ERR; a set in the same cycle wins over the clear.
- Flush:
  - i_FLUSH has the highest synchronous priority.
  - Pointers and count go to 0 and o_EMPTY goes to 1.
  - Concurrent i_W_INC and i_R_INC are ignored, with no error flags set.
  - Error flags and o_RD_DATA are unaffected.
- An asynchronous reset asserted mid-operation takes effect immediately; no write completes in that cycle.

Decomposition:
- Shared package (or header) holds:
  - the DEPTH derivation function;
  - default threshold constants: AFULL = DEPTH-2, AEMPTY = 1.
- One sub-module, fifo_mem_2p:
  - register-array memory;
  - synchronous write port;
  - asynchronous read port;
  - no reset.
- Pointer, count and flag logic stay in sync_fifo_thr.

Test Plan:
1. Reset, write 10, 20, 80, 30, then 4 reads (FWFT=0) -> o_RD_DATA = 10, 20, 80, 30, each one edge after its read; o_COUNT goes 4 -> 0; o_EMPTY = 1 after the 4th read.
2. Write 40, 50, …, 120 (9 words) into the empty FIFO -> o_FULL = 1 after the 8th write; 120 is dropped; o_OVERFLOW = 1; o_COUNT = 8; 8 reads return 40 … 110.
3. i_AFULL_TH = 6, i_AEMPTY_TH = 2 -> o_ALMOST_EMPTY = 1 at counts 0–2 and 0 at count 3; o_ALMOST_FULL = 1 at counts 6–8.
4. Full FIFO, i_W_INC = i_R_INC = 1 for 3 cycles with data 0xA1–0xA3 -> o_COUNT stays 8, o_FULL stays 1, o_OVERFLOW stays 0; data order is preserved on drain.
5. Read on empty -> o_UNDERFLOW = 1 and o_RD_DATA unchanged; then i_CLR_ERR -> o_UNDERFLOW = 0 next edge. i_FLUSH at count 5 with i_W_INC = 1 -> o_COUNT = 0 and o_EMPTY = 1 next edge; the write is dropped.
6. FWFT=1 instance: write 0x55 into the empty FIFO -> o_RD_DATA = 0x55 one edge later with no i_R_INC. Then assert i_RST mid-stream at count 5 -> o_COUNT = 0 and o_EMPTY = 1 immediately, before the next edge.
